vedic_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined 32x32 Vedic multiplier among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle into the multiplier. A tag shift register tracks each in-flight product and returns it to the requester that issued it, holding it until that requester accepts it. The block sits between the matrix-multiply lane controllers and the single multiplier instance.

---
 rtl/vedic_mul_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: round-robin sharing of one pipelined 32x32 multiplier among N_REQ requesters.
// Ports: clk/reset_n (sync, active-low); req_valid/req_ready/req_a/req_b operand handshake per requester;
// resp_valid/resp_ready/resp_data product return per requester; mul_a/mul_b/mul_result multiplier side;
// busy (any operation pending); op_count (completed response handshakes, wrapping).
module vedic_mul_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [64*N_REQ-1:0]  resp_data,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [63:0]          mul_result,
  output logic                 busy,
  output logic [31:0]          op_count
);
  localparam int IW = $clog2(N_REQ);
  // One extra stage covers the operand register in front of the multiplier.
  localparam int D  = MUL_LATENCY + 1;

  logic [N_REQ-1:0][31:0] a_v, b_v;
  logic [N_REQ-1:0][63:0] rd_q, rd_d;
  logic [N_REQ-1:0]       pend_q, pend_d, rv_q, rv_d, elig, hs, gnt_oh, cap_oh;
  logic [IW-1:0]          rr_q, rr_d, gid, lo, hi;
  logic                   hi_ok, gnt;
  logic [D-1:0]           tv_q;
  logic [D-1:0][IW-1:0]   tid_q;
  logic [31:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d, op_count_q, op_count_d;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign elig = req_valid & ~pend_q;
  assign hs   = rv_q & resp_ready;

  // Round-robin: lowest eligible index at or above rr_q, else lowest eligible overall.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_ok = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) lo = IW'(i);
      if (elig[i] && IW'(i) >= rr_q) begin
        hi = IW'(i);
        hi_ok = 1'b1;
      end
    end
    gid = hi_ok ? hi : lo;
    gnt = reset_n && |elig;
    gnt_oh = gnt ? N_REQ'(1) << gid : '0;
    cap_oh = tv_q[D-1] ? N_REQ'(1) << tid_q[D-1] : '0;
    rr_d = !gnt ? rr_q : (gid == IW'(N_REQ - 1)) ? '0 : gid + IW'(1);
    pend_d = (pend_q & ~hs) | gnt_oh;
    rv_d = (rv_q & ~hs) | cap_oh;
    mul_a_d = gnt ? a_v[gid] : mul_a_q;
    mul_b_d = gnt ? b_v[gid] : mul_b_q;
    op_count_d = op_count_q;
    for (int i = 0; i < N_REQ; i++) begin
      op_count_d = op_count_d + 32'(hs[i]);
      rd_d[i] = cap_oh[i] ? mul_result : rd_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q     <= '0;
      rv_q       <= '0;
      rd_q       <= '0;
      rr_q       <= '0;
      tv_q       <= '0;
      tid_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      op_count_q <= '0;
    end else begin
      pend_q     <= pend_d;
      rv_q       <= rv_d;
      rd_q       <= rd_d;
      rr_q       <= rr_d;
      tv_q       <= {tv_q[D-2:0], gnt};
      tid_q      <= {tid_q[D-2:0], gid};
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready  = gnt_oh;
  assign resp_valid = rv_q;
  assign resp_data  = rd_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign op_count   = op_count_q;
  assign busy       = reset_n & |pend_q;
endmodule
